// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned MAT_N     = 3;
  localparam int unsigned MAT_ELEMS = 9;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RES_W     = 16;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StFire,
    StWait,
    StDrain
  } state_e;

  // Row-major element index used for every flat-bus packing.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return MAT_N * r + c;
  endfunction

endpackage

// File: rtl/matmul_operand_buf.sv
// 9x8 write-indexed operand register file with a flat row-major read port.
module matmul_operand_buf
  import matmul_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [3:0]                     waddr,
  input  logic [DATA_W-1:0]              wdata,
  output logic [MAT_ELEMS*DATA_W-1:0]    flat
);

  logic [DATA_W-1:0] mem_q [MAT_ELEMS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAT_ELEMS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAT_ELEMS; i++) begin
        if (we && (waddr == 4'(i))) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int r = 0; r < MAT_N; r++) begin
      for (int c = 0; c < MAT_N; c++) begin
        flat[DATA_W*idx(r, c) +: DATA_W] = mem_q[idx(r, c)];
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 3x3 multiplier: loads A/B bytes, fires, waits, drains results.
// Optional MATCTL_PERF_EN adds a per-job cycle counter output (perf_cycles).
module matmul_seq_ctrl #(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RES_W       = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_W-1:0]                       in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [RES_W-1:0]                        out_data,
  output logic                                    out_last,
  output logic                                    busy,
  output logic [matmul_pkg::MAT_ELEMS*DATA_W-1:0] a_flat,
  output logic [matmul_pkg::MAT_ELEMS*DATA_W-1:0] b_flat,
  output logic                                    mul_en,
  input  logic [matmul_pkg::MAT_ELEMS*RES_W-1:0]  mul_result
`ifdef MATCTL_PERF_EN
  ,
  output logic [31:0]                             perf_cycles
`endif
);

  import matmul_pkg::*;

  localparam logic [2:0] WaitLast = 3'(MUL_LATENCY - 1);
  localparam logic [3:0] LastIdx  = 4'(MAT_ELEMS - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic [2:0]                 wait_q, wait_d;
  logic [MAT_ELEMS*RES_W-1:0] res_q, res_d;

  logic in_xfer, out_xfer, last_beat;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_beat = (idx_q == LastIdx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadA;
      idx_q   <= '0;
      wait_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    res_d   = res_q;
    case (state_q)
      StLoadA, StLoadB: begin
        if (in_xfer) begin
          if (last_beat) begin
            state_d = (state_q == StLoadA) ? StLoadB : StFire;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StFire: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        // Capture before draining so output back-pressure cannot lose the product.
        if (wait_q == WaitLast) begin
          res_d   = mul_result;
          state_d = StDrain;
          idx_d   = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StDrain: begin
        if (out_xfer) begin
          if (last_beat) begin
            state_d = StLoadA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StLoadA;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
    mul_en    = (state_q == StFire);
    out_valid = (state_q == StDrain);
    out_data  = out_valid ? res_q[RES_W*idx_q +: RES_W] : '0;
    out_last  = out_valid && last_beat;
    busy      = !((state_q == StLoadA) && (idx_q == '0));
  end

  matmul_operand_buf u_a_buf (
    .clk   (clk),
    .rst   (rst),
    .we    ((state_q == StLoadA) && in_valid),
    .waddr (idx_q),
    .wdata (in_data),
    .flat  (a_flat)
  );

  matmul_operand_buf u_b_buf (
    .clk   (clk),
    .rst   (rst),
    .we    ((state_q == StLoadB) && in_valid),
    .waddr (idx_q),
    .wdata (in_data),
    .flat  (b_flat)
  );

`ifdef MATCTL_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d, perf_q, perf_d;
  logic [31:0] perf_inc;

  assign perf_inc    = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
  assign perf_cycles = perf_q;

  // The first A transfer cycle itself counts, so the counter restarts at 1.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_d     = perf_q;
    if ((state_q == StLoadA) && (idx_q == '0) && in_xfer) begin
      perf_cnt_d = 32'd1;
    end else if (busy) begin
      perf_cnt_d = perf_inc;
    end
    if (out_xfer && last_beat) begin
      perf_d = perf_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_q     <= perf_d;
    end
  end
`endif

endmodule
